draw_cell_overlay: RTL and testbench
====================================

DRAW_CELL_OVERLAY -- requirements
Module: draw_cell_overlay

Interface
REQ-001 The block SHALL take the following parameters (name, default, meaning):
- N, 3, cells per board side; board has N*N cells, 2..4 supported.
- BOARD_X0, 0, first board pixel column.
- BOARD_Y0, 0, first board pixel row.
- CELL_W, 341, cell width in pixels.
- CELL_H, 256, cell height in pixels.
- BLINK_FRAMES, 30, frames per blink half-period, >=1.
- COLOR_SEL, 12'hff0, fill colour for selected cells.
- COLOR_WIN, 12'h0f0, fill colour for winning cells.

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- pclk, in, 1, pixel clock.
- rst_n, in, 1, asynchronous active-low reset.
- hcount_in / vcount_in, in, 11 each, timing counters.
- hsync_in / vsync_in / hblnk_in / vblnk_in, in, 1 each, timing strobes.
- rgb_in, in, 12, upstream pixel.
- sel_mask, in, N*N, selected cells; bit i = row*N+col.
- win_mask, in, N*N, winning cells.
- blink_en, in, 1, blink winning cells.
- hcount_out / vcount_out, out, 11 each, delayed timing counters.
- hsync_out / vsync_out / hblnk_out / vblnk_out, out, 1 each, delayed timing strobes.
- rgb_out, out, 12, composited pixel.

REQ-003 The design SHALL use one clock (pclk); reset SHALL be asynchronous and active-low (rst_n).

Function
REQ-004 The design SHALL be a 2-stage pipeline.
- Every *_out signal SHALL equal the corresponding *_in signal delayed exactly 2 pclk cycles.

REQ-005 Stage 1 SHALL compute, from hcount_in/vcount_in:
- in_board, cell column and cell row.
- A pixel is in column c iff BOARD_X0+c*CELL_W <= hcount_in < BOARD_X0+(c+1)*CELL_W (inclusive start, exclusive end); rows likewise with BOARD_Y0/CELL_H.
- Comparisons use 12-bit unsigned arithmetic; no division.

REQ-006 Pixels with hcount_in >= BOARD_X0+N*CELL_W or vcount_in >= BOARD_Y0+N*CELL_H SHALL be out of board.

REQ-007 Masks SHALL be double-buffered:
- sel_mask/win_mask SHALL be sampled into shadow registers on the first cycle vsync_in is seen high after being low (rising edge).
- Only the shadow copies SHALL drive colouring; mid-frame mask changes SHALL have no effect until the next vsync rising edge.

REQ-008 A frame counter SHALL increment on each vsync rising edge and SHALL wrap to 0 after reaching BLINK_FRAMES-1.
- blink_phase SHALL toggle at each wrap.
- blink_phase SHALL be sampled into a shadow register at the same edge as the masks.

REQ-009 Stage 2 colour priority (cell index i, shadow values):
- hblnk or vblnk (stage-1 delayed) high or out of board -> rgb_in delayed.
- win_shadow[i]=1 and (blink_en_shadow=0 or blink_phase_shadow=1) -> COLOR_WIN.
- win_shadow[i]=1, blink_en_shadow=1, blink_phase_shadow=0 -> fall through to the selection rule.
- sel_shadow[i]=1 -> COLOR_SEL.
- Otherwise -> rgb_in delayed.

REQ-010 blink_en SHALL be shadowed together with the masks.

REQ-011 The frame counter SHALL advance regardless of blink_en.

REQ-012 vsync held high across many cycles SHALL count as one edge; a vsync edge coincident with a board pixel SHALL still apply to that pixel only from the next cycle's stage-1 sample.

Reset
REQ-013 While rst_n=0 the following SHALL be 0 immediately, with no pclk required:
- all outputs and pipeline registers;
- shadow masks, frame counter, blink_phase, vsync edge history.

REQ-014 After rst_n rises, the first valid output SHALL appear 2 cycles after the first sampled input.
- Until the first vsync rising edge, masks are zero, so rgb_out passes rgb_in.

REQ-015 Reset asserted mid-frame SHALL abort the frame; no stale highlight SHALL appear after release.

Verification
REQ-016 Latency: drive hcount_in=100, rgb_in=12'h123, masks 0 -> hcount_out=100 and rgb_out=12'h123 exactly 2 cycles later.

REQ-017 Edges, defaults, sel_mask=9'b1_0000_0000 latched at vsync:
- (hcount,vcount)=(682,512) -> COLOR_SEL.
- (681,512) -> rgb_in.
- (1023,767) -> rgb_in (out of board).

REQ-018 Shadowing: change sel_mask mid-frame -> no output change until the line after the next vsync rising edge.

REQ-019 Blink, BLINK_FRAMES=2, win_mask bit 4 set, blink_en=1:
- cell (1,1) SHALL alternate COLOR_WIN / underlying colour every 2 frames.
- With sel bit 4 also set, the underlying colour is COLOR_SEL.

REQ-020 Priority: win and sel both set on bit 0, blink_en=0 -> COLOR_WIN.

REQ-021 Reset: pull rst_n low mid-frame with masks latched -> all outputs 0 asynchronously; after release with no vsync edge -> rgb_out = rgb_in delayed 2.

Source files
------------

// File: rtl/draw_cell_overlay.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// draw_cell_overlay
//
// Two-stage video pipeline that paints the cells of an N x N game board on top
// of the upstream pixel stream. Selected cells are filled with COLOR_SEL and
// winning cells with COLOR_WIN. Winning cells can blink. The blink period is
// counted in frames.
//
// Mask inputs are double-buffered. They are copied into shadow registers on
// each vsync rising edge, so a picture never changes mid-frame.
//
// Ports
//   pclk                 pixel clock
//   rst_n                asynchronous active-low reset
//   hcount_in/vcount_in  pixel position from the timing generator (11 bit)
//   hsync_in/vsync_in    sync strobes
//   hblnk_in/vblnk_in    blanking strobes
//   rgb_in               upstream pixel (12 bit, 4:4:4)
//   sel_mask             selected cells, bit i = row*N + col
//   win_mask             winning cells, same indexing
//   blink_en             blink the winning cells
//   *_out                the matching *_in delayed by two pclk cycles
//   rgb_out              composited pixel, delayed by two pclk cycles
// -----------------------------------------------------------------------------
module draw_cell_overlay #(
    parameter int          N            = 3,
    parameter int          BOARD_X0     = 0,
    parameter int          BOARD_Y0     = 0,
    parameter int          CELL_W       = 341,
    parameter int          CELL_H       = 256,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [11:0] COLOR_SEL    = 12'hff0,
    parameter logic [11:0] COLOR_WIN    = 12'h0f0
) (
    input  logic           pclk,
    input  logic           rst_n,
    input  logic [10:0]    hcount_in,
    input  logic [10:0]    vcount_in,
    input  logic           hsync_in,
    input  logic           vsync_in,
    input  logic           hblnk_in,
    input  logic           vblnk_in,
    input  logic [11:0]    rgb_in,
    input  logic [N*N-1:0] sel_mask,
    input  logic [N*N-1:0] win_mask,
    input  logic           blink_en,
    output logic [10:0]    hcount_out,
    output logic [10:0]    vcount_out,
    output logic           hsync_out,
    output logic           vsync_out,
    output logic           hblnk_out,
    output logic           vblnk_out,
    output logic [11:0]    rgb_out
);

    localparam int          CELLS      = N * N;
    localparam int          IW         = $clog2(CELLS);
    localparam int          FW         = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [11:0] X0         = 12'(BOARD_X0);
    localparam logic [11:0] Y0         = 12'(BOARD_Y0);
    localparam logic [11:0] BOARD_W    = 12'(N * CELL_W);
    localparam logic [11:0] BOARD_H    = 12'(N * CELL_H);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    // ---------------- frame-rate state: vsync edge, blink, shadows ----------
    logic             vsync_prev;
    logic             vsync_rise;
    logic [FW-1:0]    frame_cnt;
    logic             blink_phase;
    logic [CELLS-1:0] sel_shadow;
    logic [CELLS-1:0] win_shadow;
    logic             blink_en_shadow;
    logic             blink_phase_shadow;

    // A long vsync pulse yields a single edge.
    assign vsync_rise = vsync_in & ~vsync_prev;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev         <= 1'b0;
            frame_cnt          <= '0;
            blink_phase        <= 1'b0;
            sel_shadow         <= '0;
            win_shadow         <= '0;
            blink_en_shadow    <= 1'b0;
            blink_phase_shadow <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (vsync_rise) begin
                sel_shadow         <= sel_mask;
                win_shadow         <= win_mask;
                blink_en_shadow    <= blink_en;
                blink_phase_shadow <= blink_phase;
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + FW'(1);
                end
            end
        end
    end

    // ---------------- stage 1: board geometry and shadow lookup -------------
    // Coordinates are made relative to the board origin. A pixel left of or
    // above the origin wraps to a large value and so fails the size test.
    logic [11:0]   hrel;
    logic [11:0]   vrel;
    logic [1:0]    col;
    logic [1:0]    row;
    logic [IW-1:0] cell_idx;
    logic          in_board;

    assign hrel = {1'b0, hcount_in} - X0;
    assign vrel = {1'b0, vcount_in} - Y0;

    // NOTE: every always_comb output gets a default first. No path can then
    // leave a value unassigned, so no latch is inferred.
    always_comb begin
        col = '0;
        row = '0;
        for (int c = 1; c < N; c++) begin
            if (hrel >= 12'(c * CELL_W)) col = 2'(c);
        end
        for (int r = 1; r < N; r++) begin
            if (vrel >= 12'(r * CELL_H)) row = 2'(r);
        end
        in_board = (hrel < BOARD_W) && (vrel < BOARD_H);
        cell_idx = IW'(int'(row) * N + int'(col));
    end

    logic [10:0] hcount_s1, vcount_s1;
    logic        hsync_s1, vsync_s1, hblnk_s1, vblnk_s1;
    logic [11:0] rgb_s1;
    logic        paint_win_s1, paint_sel_s1;

    // The shadows are read here, at stage 1. A vsync edge that coincides
    // with a pixel therefore takes effect from the following pixel.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_s1    <= '0;
            vcount_s1    <= '0;
            hsync_s1     <= 1'b0;
            vsync_s1     <= 1'b0;
            hblnk_s1     <= 1'b0;
            vblnk_s1     <= 1'b0;
            rgb_s1       <= '0;
            paint_win_s1 <= 1'b0;
            paint_sel_s1 <= 1'b0;
        end else begin
            hcount_s1    <= hcount_in;
            vcount_s1    <= vcount_in;
            hsync_s1     <= hsync_in;
            vsync_s1     <= vsync_in;
            hblnk_s1     <= hblnk_in;
            vblnk_s1     <= vblnk_in;
            rgb_s1       <= rgb_in;
            // A blinking winner in its dark phase falls through to selection.
            paint_win_s1 <= in_board && win_shadow[cell_idx]
                            && (!blink_en_shadow || blink_phase_shadow);
            paint_sel_s1 <= in_board && sel_shadow[cell_idx];
        end
    end

    // ---------------- stage 2: colour mux -----------------------------------
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s1;
            vcount_out <= vcount_s1;
            hsync_out  <= hsync_s1;
            vsync_out  <= vsync_s1;
            hblnk_out  <= hblnk_s1;
            vblnk_out  <= vblnk_s1;
            if (hblnk_s1 || vblnk_s1) rgb_out <= rgb_s1;
            else if (paint_win_s1)    rgb_out <= COLOR_WIN;
            else if (paint_sel_s1)    rgb_out <= COLOR_SEL;
            else                      rgb_out <= rgb_s1;
        end
    end

endmodule

// File: tb/tb_draw_cell_overlay.sv
`timescale 1ns/1ps
module tb_draw_cell_overlay;

    localparam int          N   = 3;
    localparam int          CW  = 341;
    localparam int          CH  = 256;
    localparam int          BF  = 2;
    localparam logic [11:0] SEL = 12'hff0;
    localparam logic [11:0] WIN = 12'h0f0;

    logic        pclk = 1'b0;
    logic        rst_n;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [8:0]  sel_mask, win_mask;
    logic        blink_en;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    draw_cell_overlay #(.N(N), .BLINK_FRAMES(BF)) dut (
        .pclk(pclk), .rst_n(rst_n),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .sel_mask(sel_mask), .win_mask(win_mask),
        .blink_en(blink_en),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs, vs, hb, vb;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   step_no = 0;

    // Reference model of the frame-rate state.
    logic [8:0] m_sel, m_win;
    logic       m_ben, m_ph_sh, m_phase, m_vs_prev;
    int         m_cnt;

    task automatic model_reset();
        m_sel = '0; m_win = '0; m_ben = 1'b0; m_ph_sh = 1'b0;
        m_phase = 1'b0; m_vs_prev = 1'b0; m_cnt = 0;
        sb.delete();
    endtask

    function automatic logic [11:0] model_rgb(input int h, input int v,
                                              input logic hb, input logic vb,
                                              input logic [11:0] rgb);
        int idx;
        if (hb || vb || h >= N * CW || v >= N * CH) return rgb;
        idx = (v / CH) * N + (h / CW);
        if (m_win[idx] && (!m_ben || m_ph_sh)) return WIN;
        if (m_sel[idx]) return SEL;
        return rgb;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] timing_out();
        return 32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out});
    endfunction

    // One pixel clock: drive, predict, then compare the pixel from one step ago.
    task automatic step(input int h, input int v, input logic vs, input logic hb,
                        input logic vb, input logic [11:0] rgb);
        exp_t        e;
        logic [10:0] hh, vv;
        hh = 11'(h);
        vv = 11'(v);
        @(negedge pclk);
        hcount_in = hh; vcount_in = vv;
        hsync_in = hh[3]; vsync_in = vs;
        hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
        e = '{h: hh, v: vv, hs: hh[3], vs: vs, hb: hb, vb: vb,
              rgb: model_rgb(h, v, hb, vb, rgb)};
        sb.push_back(e);
        if (vs && !m_vs_prev) begin
            m_sel = sel_mask; m_win = win_mask; m_ben = blink_en; m_ph_sh = m_phase;
            if (m_cnt == BF - 1) begin
                m_cnt = 0;
                m_phase = !m_phase;
            end else begin
                m_cnt++;
            end
        end
        m_vs_prev = vs;
        step_no++;
        @(posedge pclk);
        #1;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            check($sformatf("rgb@step%0d", step_no - 1), 32'(rgb_out), 32'(e.rgb));
            check($sformatf("timing@step%0d", step_no - 1), timing_out(),
                  32'({e.h, e.v, e.hs, e.vs, e.hb, e.vb}));
        end
    endtask

    task automatic pix(input int h, input int v, input logic [11:0] rgb);
        step(h, v, 1'b0, 1'b0, 1'b0, rgb);
    endtask

    // vsync high for two cycles during blanking: this must count as one edge.
    task automatic vs_pulse();
        step(1100, 770, 1'b1, 1'b1, 1'b1, 12'h000);
        step(1100, 771, 1'b1, 1'b1, 1'b1, 12'h000);
        step(1100, 772, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    initial begin
        rst_n = 1'b0;
        hcount_in = '0; vcount_in = '0; hsync_in = 1'b0; vsync_in = 1'b0;
        hblnk_in = 1'b0; vblnk_in = 1'b0; rgb_in = '0;
        sel_mask = '0; win_mask = '0; blink_en = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge pclk);
        #1;
        check("reset_rgb", 32'(rgb_out), 32'h0);
        check("reset_timing", timing_out(), 32'h0);

        @(negedge pclk);
        rst_n = 1'b1;

        // Latency with zero shadows: mask inputs set but not yet latched.
        sel_mask = '1;
        pix(100, 0, 12'h123);
        pix(200, 300, 12'h456);
        pix(500, 600, 12'h789);
        step(1100, 800, 1'b0, 1'b1, 1'b1, 12'h0aa);

        // Cell edges with only cell 8 selected.
        sel_mask = 9'b1_0000_0000;
        vs_pulse();
        pix(682, 512, 12'h321);
        pix(681, 512, 12'h321);
        pix(1023, 767, 12'h321);
        pix(1022, 767, 12'h654);
        pix(682, 511, 12'h111);
        step(682, 512, 1'b0, 1'b1, 1'b0, 12'h222);

        // Mid-frame mask change is ignored until the next vsync edge.
        sel_mask = 9'b0_0000_0001;
        pix(682, 512, 12'h333);
        pix(0, 0, 12'h333);
        step(0, 0, 1'b1, 1'b0, 1'b0, 12'h444);
        step(5, 5, 1'b0, 1'b0, 1'b0, 12'h444);
        pix(682, 512, 12'h444);

        // Win beats select when blink is off.
        win_mask = 9'b0_0000_0001;
        sel_mask = 9'b0_0000_0001;
        blink_en = 1'b0;
        vs_pulse();
        pix(0, 0, 12'h555);
        pix(341, 0, 12'h555);

        // Blink of cell (1,1), first over the raw pixel, then over selection.
        win_mask = 9'b0_0001_0000;
        sel_mask = '0;
        blink_en = 1'b1;
        for (int f = 0; f < 6; f++) begin
            vs_pulse();
            pix(400, 300, 12'h0a5);
            pix(0, 0, 12'h0a5);
        end
        sel_mask = 9'b0_0001_0000;
        for (int f = 0; f < 4; f++) begin
            vs_pulse();
            pix(400, 300, 12'h0a5);
            pix(681, 511, 12'h0a5);
        end

        // Asynchronous reset mid-frame.
        pix(400, 300, 12'h777);
        pix(401, 300, 12'h777);
        @(negedge pclk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_rgb", 32'(rgb_out), 32'h0);
        check("async_reset_timing", timing_out(), 32'h0);
        model_reset();
        repeat (2) @(posedge pclk);
        @(negedge pclk);
        rst_n = 1'b1;

        // No stale highlight after release.
        pix(400, 300, 12'h777);
        pix(400, 301, 12'h778);
        pix(682, 512, 12'h888);
        pix(0, 0, 12'h999);
        pix(10, 10, 12'h000);
        pix(10, 10, 12'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
